// File: rtl/input_queue_controller_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | input_queue_controller_pkg                                               |
// | Shared constants, state encoding and helpers for the input queue ctrl.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package input_queue_controller_pkg;

  localparam int INPUT_LAYER_NODES = 784;
  localparam int QUEUE_MAX_SIZE    = 256;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  typedef enum logic [3:0] {
    IQC_S_IDLE    = 4'd0,
    IQC_S_ARM     = 4'd1,
    IQC_S_LOAD    = 4'd2,
    IQC_S_SETTLE  = 4'd3,
    IQC_S_SNAP    = 4'd4,
    IQC_S_SNAP_LO = 4'd5,
    IQC_S_CHK     = 4'd6,
    IQC_S_CAP     = 4'd7,
    IQC_S_WAIT    = 4'd8,
    IQC_S_DONE    = 4'd9
  } iqcState_t;

  // Ones counter sticks at its ceiling instead of wrapping.
  function automatic logic [9:0] satIncrement(input logic [9:0] value, input logic bump);
    if (bump && (value != 10'd1023)) begin
      return value + 10'd1;
    end
    return value;
  endfunction

endpackage
`default_nettype wire

// File: rtl/input_queue_controller_drain_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | iqc_drain_timer                                                          |
// | Counts stalled drain cycles; only built when IQC_DRAIN_TIMEOUT_EN is set. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`ifdef IQC_DRAIN_TIMEOUT_EN
module iqc_drain_timer #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic resetInputQueue,
  input  logic restart,
  input  logic stall,
  output logic expired
);

  localparam int c_cntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_cntW-1:0] c_lastCnt = c_cntW'(TIMEOUT_CYCLES - 1);

  logic [c_cntW-1:0] r_stallCnt;

  always_ff @(posedge clk or posedge resetInputQueue) begin
    if (resetInputQueue) begin
      r_stallCnt <= '0;
    end else if (restart) begin
      r_stallCnt <= '0;
    end else if (stall && (r_stallCnt != c_lastCnt)) begin
      r_stallCnt <= r_stallCnt + c_cntW'(1);
    end
  end

  // Fires during the TIMEOUT_CYCLES-th stalled cycle so the controller reacts on that edge.
  assign expired = stall && (r_stallCnt == c_lastCnt);

endmodule
`endif
`default_nettype wire

// File: rtl/input_queue_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | input_queue_controller                                                   |
// | Loads one frame into the input queue, snapshots it, drains indices.      |
// | Optional drain stall timeout: IQC_DRAIN_TIMEOUT_EN.                      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module input_queue_controller
  import input_queue_controller_pkg::*;
#(
  parameter int N_PIXELS    = INPUT_LAYER_NODES,
  parameter int QUEUE_DEPTH = QUEUE_MAX_SIZE
`ifdef IQC_DRAIN_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic       clk,
  input  logic       resetInputQueue,
  input  logic       start,
  input  logic       pixelIn,
  input  logic       pixelValid,
  output logic       pixelReady,
  output logic       queueClear,
  output logic       bufferClear,
  output logic       pixelValue,
  output logic       writeBufferEnable,
  output logic       dequeue,
  input  logic       finished,
  input  logic       queueEmpty,
  input  logic [9:0] indexIn,
  output logic       indexValid,
  input  logic       indexReady,
  output logic [9:0] indexData,
  output logic       frameDone,
  output logic [9:0] activeCount,
  output logic       error
);

  localparam int c_pixW = $clog2(N_PIXELS + 1);
  localparam logic [c_pixW-1:0] c_lastPix = c_pixW'(N_PIXELS - 1);
  localparam logic [10:0] c_queueDepth = 11'(QUEUE_DEPTH);
  localparam logic c_singlePixel = (N_PIXELS == 1);

  iqcState_t         r_state;
  logic [c_pixW-1:0] r_pixCnt;
  logic [9:0]        r_onesCnt;

`ifdef IQC_DRAIN_TIMEOUT_EN
  logic w_drainRestart;
  logic w_drainStall;
  logic w_drainExpired;

  assign w_drainRestart = (r_state == IQC_S_CAP) && !dequeue;
  assign w_drainStall   = (r_state == IQC_S_WAIT) && indexValid && !indexReady;

  iqc_drain_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_drainTimer (
    .clk            (clk),
    .resetInputQueue(resetInputQueue),
    .restart        (w_drainRestart),
    .stall          (w_drainStall),
    .expired        (w_drainExpired)
  );
`endif

  always_ff @(posedge clk or posedge resetInputQueue) begin
    if (resetInputQueue) begin
      r_state           <= IQC_S_IDLE;
      r_pixCnt          <= '0;
      r_onesCnt         <= '0;
      pixelReady        <= FALSE;
      queueClear        <= TRUE;
      bufferClear       <= TRUE;
      pixelValue        <= FALSE;
      writeBufferEnable <= FALSE;
      dequeue           <= FALSE;
      indexValid        <= FALSE;
      indexData         <= '0;
      frameDone         <= FALSE;
      activeCount       <= '0;
      error             <= FALSE;
    end else begin
      frameDone <= FALSE;
      error     <= FALSE;
      case (r_state)
        IQC_S_IDLE: begin
          queueClear  <= TRUE;
          bufferClear <= FALSE;
          pixelValue  <= FALSE;
          if (start) begin
            r_pixCnt   <= '0;
            r_onesCnt  <= '0;
            pixelReady <= TRUE;
            r_state    <= IQC_S_ARM;
          end
        end
        IQC_S_ARM: begin
          if (pixelValid) begin
            pixelValue <= pixelIn;
            queueClear <= FALSE;
            r_pixCnt   <= c_pixW'(1);
            r_onesCnt  <= {9'd0, pixelIn};
            pixelReady <= !c_singlePixel;
            r_state    <= c_singlePixel ? IQC_S_SETTLE : IQC_S_LOAD;
          end
        end
        IQC_S_LOAD: begin
          // The queue samples pixelValue every clock, so a missing beat corrupts the frame.
          if (pixelValid) begin
            pixelValue <= pixelIn;
            r_pixCnt   <= r_pixCnt + c_pixW'(1);
            r_onesCnt  <= satIncrement(r_onesCnt, pixelIn);
            if (r_pixCnt == c_lastPix) begin
              pixelReady <= FALSE;
              r_state    <= IQC_S_SETTLE;
            end
          end else begin
            error      <= TRUE;
            pixelReady <= FALSE;
            pixelValue <= FALSE;
            queueClear <= TRUE;
            r_state    <= IQC_S_IDLE;
          end
        end
        IQC_S_SETTLE: begin
          pixelValue <= FALSE;
          if (finished) begin
            if ({1'b0, r_onesCnt} > c_queueDepth) begin
              error      <= TRUE;
              queueClear <= TRUE;
              r_state    <= IQC_S_IDLE;
            end else begin
              writeBufferEnable <= TRUE;
              r_state           <= IQC_S_SNAP;
            end
          end
        end
        IQC_S_SNAP: begin
          writeBufferEnable <= FALSE;
          r_state           <= IQC_S_SNAP_LO;
        end
        IQC_S_SNAP_LO: begin
          r_state <= IQC_S_CHK;
        end
        IQC_S_CHK: begin
          if (queueEmpty) begin
            frameDone   <= TRUE;
            activeCount <= r_onesCnt;
            r_state     <= IQC_S_DONE;
          end else begin
            dequeue <= TRUE;
            r_state <= IQC_S_CAP;
          end
        end
        IQC_S_CAP: begin
          // First cycle retires the strobe; the queue's indexOut is valid on the second.
          if (dequeue) begin
            dequeue <= FALSE;
          end else begin
            indexData  <= indexIn;
            indexValid <= TRUE;
            r_state    <= IQC_S_WAIT;
          end
        end
        IQC_S_WAIT: begin
          if (indexReady) begin
            indexValid <= FALSE;
            r_state    <= IQC_S_CHK;
          end
`ifdef IQC_DRAIN_TIMEOUT_EN
          else if (w_drainExpired) begin
            error      <= TRUE;
            indexValid <= FALSE;
            queueClear <= TRUE;
            r_state    <= IQC_S_IDLE;
          end
`endif
        end
        IQC_S_DONE: begin
          queueClear <= TRUE;
          r_state    <= IQC_S_IDLE;
        end
        default: begin
          r_state <= IQC_S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_input_queue_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_input_queue_controller                                                |
// | Directed frames against a queue stand-in; scoreboard of expected indices.|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_input_queue_controller;

  localparam int NPIX = 16;
  localparam int QD   = 8;

  logic       clk = 1'b0;
  logic       resetInputQueue = 1'b1;
  logic       start = 1'b0;
  logic       pixelIn = 1'b0;
  logic       pixelValid = 1'b0;
  logic       pixelReady, queueClear, bufferClear, pixelValue, writeBufferEnable, dequeue;
  logic       finished = 1'b0;
  logic       queueEmpty = 1'b1;
  logic [9:0] indexIn = '0;
  logic       indexValid;
  logic       indexReady = 1'b1;
  logic [9:0] indexData;
  logic       frameDone;
  logic [9:0] activeCount;
  logic       error;

  always #5 clk = ~clk;

  input_queue_controller #(
    .N_PIXELS   (NPIX),
    .QUEUE_DEPTH(QD)
`ifdef IQC_DRAIN_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES(8)
`endif
  ) dut (
    .clk              (clk),
    .resetInputQueue  (resetInputQueue),
    .start            (start),
    .pixelIn          (pixelIn),
    .pixelValid       (pixelValid),
    .pixelReady       (pixelReady),
    .queueClear       (queueClear),
    .bufferClear      (bufferClear),
    .pixelValue       (pixelValue),
    .writeBufferEnable(writeBufferEnable),
    .dequeue          (dequeue),
    .finished         (finished),
    .queueEmpty       (queueEmpty),
    .indexIn          (indexIn),
    .indexValid       (indexValid),
    .indexReady       (indexReady),
    .indexData        (indexData),
    .frameDone        (frameDone),
    .activeCount      (activeCount),
    .error            (error)
  );

  // Stand-in for the attached InputQueueRegister: indexes pixelValue every clock
  // while not cleared, snapshots into a buffer, and loads indexOut on dequeue.
  int qMem[16];
  int bMem[16];
  int qLen = 0, qCnt = 0, bLen = 0, bHead = 0;
  logic [9:0] idxOut = '0;

  always @(posedge clk) begin
    if (queueClear) begin
      qCnt = 0;
      qLen = 0;
    end else if (qCnt < NPIX) begin
      if (pixelValue && qLen < QD) begin
        qMem[qLen] = qCnt;
        qLen++;
      end
      qCnt++;
    end
    if (bufferClear) begin
      bLen = 0;
      bHead = 0;
    end else if (writeBufferEnable) begin
      for (int k = 0; k < 16; k++) bMem[k] = qMem[k];
      bLen = qLen;
      bHead = 0;
    end else if (dequeue && bHead < bLen) begin
      idxOut = 10'(bMem[bHead]);
      bHead++;
    end
    finished   <= (qCnt == NPIX);
    queueEmpty <= (bHead >= bLen);
    indexIn    <= idxOut;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nChecks = 0;
  int nErrors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic failTimeout(input string name);
    nChecks++;
    nErrors++;
    $display("FAIL %s: timed out", name);
  endtask

  // Model: a frame's expected indices are the positions of its ones, in ascending order.
  int expIdx[$];
  int obsIdx[$];
  int expCount = 0;
  int hsCnt = 0, deqCnt = 0, doneCnt = 0, errCnt = 0;
  int lastWbeCyc = 0, lastDoneCyc = 0;
  logic qcAtErr = 1'b0;
  logic pValid = 1'b0, pReady = 1'b0, pDeq = 1'b0, pErr = 1'b0;
  logic [9:0] pData = '0;

  always @(negedge clk) begin
    if (resetInputQueue) begin
      pValid = 1'b0;
      pReady = 1'b0;
      pDeq   = 1'b0;
      pErr   = 1'b0;
    end else begin
      if (indexValid && pValid && !pReady) check("indexData held", indexData, pData);
      if (indexValid && indexReady) begin
        hsCnt++;
        obsIdx.push_back(int'(indexData));
        check("index expected", (expIdx.size() > 0), 1);
        if (expIdx.size() > 0) begin
          check("index value", indexData, expIdx[0]);
          void'(expIdx.pop_front());
        end
      end
      if (dequeue) begin
        deqCnt++;
        check("dequeue one cycle", pDeq, 0);
      end
      if (writeBufferEnable) lastWbeCyc = cyc;
      if (frameDone) begin
        doneCnt++;
        lastDoneCyc = cyc;
        check("activeCount", activeCount, expCount);
        check("all indices drained", expIdx.size(), 0);
      end
      if (error) begin
        errCnt++;
        qcAtErr = queueClear;
        check("error one cycle", pErr, 0);
      end
      pValid = indexValid;
      pReady = indexReady;
      pData  = indexData;
      pDeq   = dequeue;
      pErr   = error;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic setExpect(input logic [15:0] bits);
    expIdx.delete();
    obsIdx.delete();
    expCount = 0;
    for (int i = 0; i < NPIX; i++) begin
      if (bits[i]) begin
        expIdx.push_back(i);
        expCount++;
      end
    end
  endtask

  task automatic clearExpect();
    expIdx.delete();
    obsIdx.delete();
  endtask

  // Starts a frame and streams its pixels; bubbleAt>0 drops pixelValid after that many beats.
  task automatic runFrame(input logic [15:0] bits, input int bubbleAt);
    int i;
    int guard;
    logic rdy;
    i = 0;
    guard = 0;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    pixelValid = 1'b1;
    pixelIn = bits[0];
    while (i < NPIX) begin
      @(negedge clk);
      rdy = pixelReady;
      @(posedge clk);
      #2;
      guard++;
      if (rdy) begin
        i++;
        if (i == bubbleAt) break;
        if (i < NPIX) pixelIn = bits[i];
      end
      if (guard > 100) begin
        failTimeout("pixel accept");
        break;
      end
    end
    pixelValid = 1'b0;
    pixelIn = 1'b0;
  endtask

  task automatic waitDone(input int limit);
    int s;
    int n;
    s = doneCnt;
    n = 0;
    while (doneCnt == s && n < limit) begin
      tick(1);
      n++;
    end
    if (doneCnt == s) failTimeout("frameDone wait");
  endtask

  task automatic waitErr(input int limit);
    int s;
    int n;
    s = errCnt;
    n = 0;
    while (errCnt == s && n < limit) begin
      tick(1);
      n++;
    end
    if (errCnt == s) failTimeout("error wait");
  endtask

  task automatic waitValid(input int limit);
    int n;
    n = 0;
    while (!indexValid && n < limit) begin
      tick(1);
      n++;
    end
    if (!indexValid) failTimeout("indexValid wait");
  endtask

  task automatic waitHandshakes(input int target, input int limit);
    int n;
    n = 0;
    while (hsCnt < target && n < limit) begin
      tick(1);
      n++;
    end
    if (hsCnt < target) failTimeout("handshake wait");
  endtask

  task automatic checkOrder(input string name, input int n, input int w0, input int w1,
                            input int w2, input int w3);
    int w[4];
    w = '{w0, w1, w2, w3};
    check(name, obsIdx.size(), n);
    if (obsIdx.size() == n) begin
      for (int k = 0; k < n; k++) check(name, obsIdx[k], w[k]);
    end
  endtask

  task automatic checkResetOutputs();
    check("reset queueClear", queueClear, 1);
    check("reset bufferClear", bufferClear, 1);
    check("reset pixelReady", pixelReady, 0);
    check("reset pixelValue", pixelValue, 0);
    check("reset writeBufferEnable", writeBufferEnable, 0);
    check("reset dequeue", dequeue, 0);
    check("reset indexValid", indexValid, 0);
    check("reset indexData", indexData, 0);
    check("reset frameDone", frameDone, 0);
    check("reset activeCount", activeCount, 0);
    check("reset error", error, 0);
  endtask

  initial begin
    int e0, d0, dn0, h0;

    resetInputQueue = 1'b1;
    tick(3);
    checkResetOutputs();
    resetInputQueue = 1'b0;
    tick(2);
    check("idle bufferClear", bufferClear, 0);
    check("idle queueClear", queueClear, 1);

    // Four active pixels, ready always high.
    setExpect(16'b0000_0100_1000_0011);
    e0 = errCnt;
    d0 = deqCnt;
    dn0 = doneCnt;
    runFrame(16'b0000_0100_1000_0011, -1);
    check("pixelReady after last beat", pixelReady, 0);
    waitDone(200);
    check("t1 activeCount", activeCount, 4);
    checkOrder("t1 index order", 4, 0, 1, 7, 10);
    check("t1 dequeue strobes", deqCnt - d0, 4);
    check("t1 frameDone pulses", doneCnt - dn0, 1);
    check("t1 errors", errCnt - e0, 0);
    tick(2);

    // All-zero frame.
    setExpect(16'h0000);
    h0 = hsCnt;
    runFrame(16'h0000, -1);
    waitDone(200);
    check("t2 frameDone after SNAP", lastDoneCyc - lastWbeCyc, 3);
    check("t2 activeCount", activeCount, 0);
    check("t2 no indices", hsCnt - h0, 0);
    tick(2);

    // Nine ones overflow the eight-entry queue.
    clearExpect();
    d0 = deqCnt;
    dn0 = doneCnt;
    runFrame(16'h01FF, -1);
    waitErr(100);
    tick(3);
    check("t3 dequeue strobes", deqCnt - d0, 0);
    check("t3 frameDone pulses", doneCnt - dn0, 0);
    check("t3 idle queueClear", queueClear, 1);
    check("t3 idle pixelReady", pixelReady, 0);
    check("t3 activeCount kept", activeCount, 0);

    // Bubble on beat 5, then a clean frame.
    clearExpect();
    qcAtErr = 1'b0;
    runFrame(16'h00F3, 5);
    waitErr(20);
    check("t4 queueClear with error", qcAtErr, 1);
    tick(2);
    setExpect(16'h8421);
    runFrame(16'h8421, -1);
    waitDone(200);
    check("t4 activeCount", activeCount, 4);
    checkOrder("t4 index order", 4, 0, 5, 10, 15);
    tick(2);

    // Downstream stalls on the third index.
    setExpect(16'b0011_0000_0001_0010);
    h0 = hsCnt;
    indexReady = 1'b1;
    runFrame(16'b0011_0000_0001_0010, -1);
    waitHandshakes(h0 + 2, 200);
    indexReady = 1'b0;
    waitValid(20);
    check("t5 stalled index", indexData, 12);
    d0 = deqCnt;
`ifdef IQC_DRAIN_TIMEOUT_EN
    e0 = errCnt;
    tick(7);
    check("t5 before timeout valid", indexValid, 1);
    check("t5 before timeout error", errCnt - e0, 0);
    tick(1);
    check("t5 timeout error", error, 1);
    check("t5 timeout drops valid", indexValid, 0);
    check("t5 no dequeue", deqCnt - d0, 0);
    clearExpect();
    indexReady = 1'b1;
    tick(2);
`else
    for (int k = 0; k < 20; k++) begin
      check("t5 valid held", indexValid, 1);
      tick(1);
    end
    check("t5 no dequeue", deqCnt - d0, 0);
    indexReady = 1'b1;
    waitDone(200);
    check("t5 activeCount", activeCount, 4);
    checkOrder("t5 index order", 4, 1, 4, 12, 13);
    tick(2);
`endif

    // Reset while an index is waiting for acceptance.
    setExpect(16'h0003);
    indexReady = 1'b0;
    runFrame(16'h0003, -1);
    waitValid(100);
    tick(2);
    resetInputQueue = 1'b1;
    #1;
    checkResetOutputs();
    tick(1);
    resetInputQueue = 1'b0;
    indexReady = 1'b1;
    clearExpect();
    tick(2);
    setExpect(16'hC000);
    runFrame(16'hC000, -1);
    waitDone(200);
    check("t6 activeCount", activeCount, 2);
    checkOrder("t6 index order", 2, 14, 15, 0, 0);

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
`default_nettype wire
